// File: rtl/dco_freq_meter_if.sv
// Measurement request/result bundle for dco_freq_meter.
// master: the meter (takes requests, produces results); slave: the controller/consumer.
interface dco_freq_meter_if #(
  parameter int unsigned GATE_W = 16,
  parameter int unsigned CNT_W  = 12,
  parameter int unsigned HP_W   = 8
) ();
  logic [GATE_W-1:0] gate_len;
  logic              start;
  logic              busy;
  logic              meas_valid;
  logic              meas_ready;
  logic [CNT_W-1:0]  meas_count;
  logic              meas_ovf;
  logic [HP_W-1:0]   hp_min;
  logic [HP_W-1:0]   hp_max;

  modport master (
    input  gate_len, start, meas_ready,
    output busy, meas_valid, meas_count, meas_ovf, hp_min, hp_max
  );

  modport slave (
    output gate_len, start, meas_ready,
    input  busy, meas_valid, meas_count, meas_ovf, hp_min, hp_max
  );
endinterface

// File: rtl/dco_freq_meter.sv
// dco_freq_meter: counts DCO rising edges over a gate window of clk cycles and
// offers the count on a valid/ready result port.
// Optional min/max half-period tracking: define DCO_FMETER_HALFPERIOD_EN.
module dco_freq_meter #(
  parameter int unsigned GATE_W = 16,
  parameter int unsigned CNT_W  = 12,
  parameter int unsigned HP_W   = 8
) (
  input logic              i_clk,
  input logic              i_rst,
  input logic              i_dco_in,
  dco_freq_meter_if.master meas
);

  typedef enum logic [1:0] {StIdle, StGate, StDone} state_e;

  state_e            r_state, w_state_next;
  logic              r_sync1, r_sync2, r_prev;
  logic              w_rise;
  logic              w_start_acc;
  logic [GATE_W-1:0] r_gate_cnt;
  logic [CNT_W-1:0]  r_count;
  logic              r_ovf;

  assign w_rise      = r_sync2 & ~r_prev;
  assign w_start_acc = (r_state == StIdle) && meas.start;

  // Two-flop synchronizer plus previous-value flop for edge detection
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_dco_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  // FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (meas.start) w_state_next = StGate;
      StGate:  if (r_gate_cnt == GATE_W'(1)) w_state_next = StDone;
      StDone:  if (meas.meas_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // FSM outputs, decoded from the state register only
  always_comb begin
    meas.busy       = 1'b0;
    meas.meas_valid = 1'b0;
    unique case (r_state)
      StGate:  meas.busy = 1'b1;
      StDone: begin
        meas.busy       = 1'b1;
        meas.meas_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Gate window counter; a zero length still yields one gate cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_gate_cnt <= '0;
    end else if (w_start_acc) begin
      r_gate_cnt <= (meas.gate_len == '0) ? GATE_W'(1) : meas.gate_len;
    end else if (r_state == StGate) begin
      r_gate_cnt <= r_gate_cnt - GATE_W'(1);
    end
  end

  // Saturating rising-edge counter with sticky overflow flag
  always_ff @(posedge i_clk) begin
    if (i_rst || w_start_acc) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if ((r_state == StGate) && w_rise) begin
      if (&r_count) r_ovf   <= 1'b1;
      else          r_count <= r_count + CNT_W'(1);
    end
  end

  assign meas.meas_count = r_count;
  assign meas.meas_ovf   = r_ovf;

`ifdef DCO_FMETER_HALFPERIOD_EN
  logic            w_edge;
  logic            r_hp_armed;
  logic [HP_W-1:0] r_hp_cnt, r_hp_min, r_hp_max;

  assign w_edge = r_sync2 ^ r_prev;

  // Half-period tracker: the first edge only arms the counter, so the partial
  // interval before it is dropped; the interval open at gate end never lands.
  always_ff @(posedge i_clk) begin
    if (i_rst || w_start_acc) begin
      r_hp_armed <= 1'b0;
      r_hp_cnt   <= '0;
      r_hp_min   <= '1;
      r_hp_max   <= '0;
    end else if (r_state == StGate) begin
      if (w_edge) begin
        if (r_hp_armed) begin
          if (r_hp_cnt < r_hp_min) r_hp_min <= r_hp_cnt;
          if (r_hp_cnt > r_hp_max) r_hp_max <= r_hp_cnt;
        end
        r_hp_armed <= 1'b1;
        r_hp_cnt   <= HP_W'(1);
      end else if (r_hp_armed && !(&r_hp_cnt)) begin
        r_hp_cnt <= r_hp_cnt + HP_W'(1);
      end
    end
  end

  assign meas.hp_min = r_hp_min;
  assign meas.hp_max = r_hp_max;
`else
  assign meas.hp_min = {HP_W{1'b1}};
  assign meas.hp_max = {HP_W{1'b0}};
`endif

endmodule

// File: doc/dco_freq_meter.md
Name: dco_freq_meter

Overview:
- Downstream measurement stage for the digitally controlled oscillator output; consumes the DCO square wave as a plain data input sampled on the system clock.
- Counts DCO rising edges over a programmable gate window of clk cycles, then presents the count on a valid/ready result port.
- Optionally tracks the minimum and maximum half-period in clk cycles, for characterising the code-to-frequency map and duty symmetry.

Parameters:
- GATE_W, 16, width of the gate-length input and gate counter
- CNT_W, 12, width of the edge-count result; the count saturates
- HP_W, 8, width of the half-period counters and min/max results; these saturate

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active high
- dco_in  input  1  DCO square wave, treated as asynchronous
- gate_len  input  GATE_W  gate window length in clk cycles, sampled on start
- start  input  1  one-cycle request to begin a measurement
- busy  output  1  high in GATE and DONE
- meas_valid  output  1  result available
- meas_ready  input  1  consumer accepts the result
- meas_count  output  CNT_W  rising edges counted in the window
- meas_ovf  output  1  edge count saturated
- hp_min  output  HP_W  shortest complete half-period (feature only)
- hp_max  output  HP_W  longest complete half-period (feature only)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all state cleared; FSM to IDLE; busy=0, meas_valid=0, meas_count=0, meas_ovf=0, hp_min=all ones, hp_max=0. Reset mid-measurement aborts with no result. Synchronizer flops also clear to 0.
- Input path: 2-flop synchronizer, then a previous-value flop. rise = s & ~p; edge = s ^ p. Latency from a dco_in transition to its edge pulse is 3 clk.
- FSM states: IDLE, GATE, DONE.
- IDLE:
  - start=1 latches gate_len; a value of 0 is treated as 1.
  - Clears the count, ovf and half-period state, then moves to GATE next cycle.
- GATE:
  - Lasts exactly the latched number of cycles. A rise in any of these cycles increments the count.
  - The count saturates at 2^CNT_W-1; meas_ovf sets when an increment is attempted at saturation.
  - After the last GATE cycle, move to DONE.
- DONE:
  - meas_valid=1; meas_count and meas_ovf stay stable.
  - When meas_valid & meas_ready, go to IDLE next cycle with meas_valid=0.
  - Results are held until overwritten by the next start.
- start is ignored outside IDLE. A start in the same cycle as the handshake is also ignored.
- Outputs are registered; nothing is combinational from inputs to outputs.

Optional Feature:
- Macro: DCO_FMETER_HALFPERIOD_EN.
- Enabled:
  - During GATE, an HP_W half-period counter starts at the first edge (either polarity).
  - At each later edge, the counter value (cycles since the previous edge) updates hp_min/hp_max, then the counter restarts at 1. The counter saturates at all ones.
  - The partial interval before the first edge is discarded. The interval still open when GATE ends is also discarded.
  - With fewer than 2 edges, hp_min stays all ones and hp_max stays 0.
- Disabled: no half-period logic is built; hp_min=all ones, hp_max=0 as constants.

Test Plan:
- dco_in toggles every 11 clk (period 22); gate_len=220; start -> after 220 GATE cycles meas_valid=1, meas_count=10, meas_ovf=0. With the feature: hp_min=hp_max=11.
- dco_in held at 0; gate_len=0 -> GATE lasts 1 cycle, meas_count=0. With the feature: hp_min=0xFF, hp_max=0.
- CNT_W=4; dco_in toggles every 1 clk; gate_len=100 -> meas_count=15, meas_ovf=1.
- Result ready and meas_ready held 0 for 50 cycles -> meas_valid stays 1 with a stable count, and a start pulse is ignored. Then meas_ready=1 for 1 cycle -> IDLE next cycle, meas_valid=0.
- Feature on; dco_in high for 5, low for 9, repeating; gate_len=200 -> hp_min=5, hp_max=9, meas_count=14 (bench-computed for the window).
- rst asserted in the 30th GATE cycle -> next cycle busy=0, meas_valid=0, meas_count=0. A new start then measures normally.
